// File: rtl/acc_cond_pkg.sv
// Shared types, widths and helpers for the accelerometer sample conditioner.
package acc_cond_pkg;

    typedef enum logic {
        CALIB = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int unsigned ACC_W           = 16;
    localparam int unsigned SAT_W           = 18;
    localparam int          GRAVITY_LSB_DEF = 1000;
    localparam int unsigned TICK_DIV_DEF    = 50000;

    // Clamp an 18-bit signed intermediate into the 16-bit signed sample range.
    function automatic logic signed [ACC_W-1:0] sat16(input logic signed [SAT_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > 18'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -18'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_mavg.sv
// Power-of-two moving average: circular window, running sum and fill tracking.
module acc_mavg
    import acc_cond_pkg::*;
#(
    parameter int unsigned AVG_SHIFT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic signed [ACC_W-1:0]        in_data,
    output logic signed [ACC_W+AVG_SHIFT-1:0] sum,
    output logic                           sum_valid,
    output logic                           full
);

    localparam int unsigned DEPTH  = 2 ** AVG_SHIFT;
    localparam int unsigned SUM_W  = ACC_W + AVG_SHIFT;
    localparam int unsigned FILL_W = AVG_SHIFT + 1;

    logic signed [ACC_W-1:0] win [DEPTH];
    logic [AVG_SHIFT-1:0]    wptr;
    logic [FILL_W-1:0]       fill;
    logic signed [ACC_W-1:0] oldest_c;
    logic signed [SUM_W-1:0] sum_next_c;
    logic                    last_fill_c;

    // Oldest entry leaves the sum only once the window has wrapped.
    always_comb begin
        oldest_c    = full ? win[wptr] : '0;
        sum_next_c  = sum + SUM_W'(in_data) - SUM_W'(oldest_c);
        last_fill_c = (fill == FILL_W'(DEPTH - 1));
    end

    // Window write, sum update and fill saturation; sum_valid marks a full-window result.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                win[i] <= '0;
            end
            wptr      <= '0;
            fill      <= '0;
            full      <= 1'b0;
            sum       <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (in_valid) begin
                win[wptr] <= in_data;
                wptr      <= wptr + AVG_SHIFT'(1);
                sum       <= sum_next_c;
                if (!full) begin
                    fill <= fill + FILL_W'(1);
                    full <= last_fill_c;
                end
                sum_valid <= full || last_fill_c;
            end
        end
    end

endmodule

// File: rtl/acc_sample_conditioner.sv
// Accelerometer conditioner: power-up bias calibration, moving average,
// offset removal with saturation and dt timestamping for the integrator.
// Optional macro ACC_COND_DEADBAND_EN snaps near-rest outputs to GRAVITY_LSB.
module acc_sample_conditioner
    import acc_cond_pkg::*;
#(
    parameter int unsigned CAL_SHIFT   = 4,
    parameter int unsigned AVG_SHIFT   = 2,
    parameter int          GRAVITY_LSB = GRAVITY_LSB_DEF,
    parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
    parameter int unsigned DEADBAND    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic        calib_start,
    output logic [15:0] acc_out,
    output logic [15:0] dt,
    output logic        out_valid,
    output logic [15:0] offset,
    output logic        calib_done
);

    localparam int unsigned CAL_W = ACC_W + CAL_SHIFT;
    localparam int unsigned SUM_W = ACC_W + AVG_SHIFT;
    localparam int unsigned CAL_N = 2 ** CAL_SHIFT;
    localparam int unsigned CNT_W = CAL_SHIFT + 1;
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DT_W  = 16;

    state_t                  state;
    logic signed [CAL_W-1:0] cal_acc;
    logic [CNT_W-1:0]        cal_cnt;
    logic [PRE_W-1:0]        prescale;
    logic [DT_W-1:0]         tick_cnt;

    logic signed [ACC_W-1:0] sample_s_c;
    logic signed [CAL_W-1:0] cal_sum_c;
    logic signed [ACC_W-1:0] cal_mean_c;
    logic signed [ACC_W-1:0] cal_off_c;
    logic                    cal_end_c;
    logic                    mavg_in_c;
    logic signed [SUM_W-1:0] mavg_sum;
    logic                    mavg_valid;
    logic                    mavg_full;
    logic signed [ACC_W-1:0] avg_c;
    logic signed [SAT_W-1:0] diff_c;
    logic signed [ACC_W-1:0] acc_sat_c;
    logic signed [ACC_W-1:0] acc_final_c;
    logic                    st2_fire_c;
    logic                    pre_wrap_c;

    // Calibration arithmetic, sample routing and stage-2 correction.
    always_comb begin
        sample_s_c = $signed(sample_in);
        cal_sum_c  = cal_acc + CAL_W'(sample_s_c);
        cal_mean_c = ACC_W'(cal_sum_c >>> CAL_SHIFT);
        cal_off_c  = sat16(SAT_W'(cal_mean_c) - SAT_W'(GRAVITY_LSB));
        cal_end_c  = !calib_start && (state == CALIB) && sample_valid
                     && (cal_cnt == CNT_W'(CAL_N - 1));
        mavg_in_c  = !calib_start && (state == RUN) && sample_valid;
        avg_c      = ACC_W'(mavg_sum >>> AVG_SHIFT);
        diff_c     = SAT_W'(avg_c) - SAT_W'($signed(offset));
        acc_sat_c  = sat16(diff_c);
        st2_fire_c = mavg_valid && mavg_full && (state == RUN) && !calib_start;
        pre_wrap_c = (prescale == PRE_W'(TICK_DIV - 1));
    end

`ifdef ACC_COND_DEADBAND_EN
    localparam logic signed [16:0] DB_S = 17'(DEADBAND);
    logic signed [16:0] dev_c;

    // Snap results within the dead-band around rest to exactly GRAVITY_LSB.
    always_comb begin
        dev_c = 17'(acc_sat_c) - 17'(GRAVITY_LSB);
        if ((dev_c <= DB_S) && (dev_c >= -DB_S)) begin
            acc_final_c = ACC_W'(GRAVITY_LSB);
        end else begin
            acc_final_c = acc_sat_c;
        end
    end
`else
    logic [31:0] unused_deadband_c;

    // Dead-band disabled: the saturated value passes straight through.
    always_comb begin
        unused_deadband_c = 32'(DEADBAND);
        acc_final_c       = acc_sat_c;
    end
`endif

    acc_mavg #(
        .AVG_SHIFT (AVG_SHIFT)
    ) u_mavg (
        .clk       (clk),
        .rst       (rst),
        .clear     (cal_end_c),
        .in_valid  (mavg_in_c),
        .in_data   (sample_s_c),
        .sum       (mavg_sum),
        .sum_valid (mavg_valid),
        .full      (mavg_full)
    );

    // Calibration FSM and registered output stage; calib_start overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CALIB;
            cal_acc    <= '0;
            cal_cnt    <= '0;
            offset     <= '0;
            calib_done <= 1'b0;
            acc_out    <= '0;
            dt         <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= st2_fire_c;
            if (st2_fire_c) begin
                acc_out <= acc_final_c;
                dt      <= tick_cnt;
            end
            if (calib_start) begin
                state      <= CALIB;
                cal_acc    <= '0;
                cal_cnt    <= '0;
                calib_done <= 1'b0;
            end else if ((state == CALIB) && sample_valid) begin
                if (cal_end_c) begin
                    offset     <= cal_off_c;
                    state      <= RUN;
                    calib_done <= 1'b1;
                    cal_acc    <= '0;
                    cal_cnt    <= '0;
                end else begin
                    cal_acc <= cal_sum_c;
                    cal_cnt <= cal_cnt + CNT_W'(1);
                end
            end
        end
    end

    // dt timer: prescaled tick count, restarted by each strobe and at calibration end.
    always_ff @(posedge clk) begin
        if (rst || cal_end_c) begin
            prescale <= '0;
            tick_cnt <= '0;
        end else begin
            prescale <= pre_wrap_c ? '0 : prescale + PRE_W'(1);
            if (st2_fire_c) begin
                tick_cnt <= pre_wrap_c ? DT_W'(1) : '0;
            end else if (pre_wrap_c && (tick_cnt != '1)) begin
                tick_cnt <= tick_cnt + DT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_acc_sample_conditioner.sv
// Directed bench for acc_sample_conditioner (TICK_DIV=10, CAL_SHIFT=4, AVG_SHIFT=2).
module tb_acc_sample_conditioner;

`ifdef ACC_COND_DEADBAND_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        calib_start = 1'b0;
    logic [15:0] acc_out;
    logic [15:0] dt;
    logic        out_valid;
    logic [15:0] offset;
    logic        calib_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        int acc;
        int dt;
    } ev_t;
    ev_t evq[$];

    typedef struct {
        int cal_val;
        int cal_last;
        int samp;
        int exp_off;
        int exp_acc;
    } vec_t;
    vec_t vecs[9];

    acc_sample_conditioner #(
        .CAL_SHIFT   (4),
        .AVG_SHIFT   (2),
        .GRAVITY_LSB (1000),
        .TICK_DIV    (10),
        .DEADBAND    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .calib_start  (calib_start),
        .acc_out      (acc_out),
        .dt           (dt),
        .out_valid    (out_valid),
        .offset       (offset),
        .calib_done   (calib_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the edge count at which it was registered.
    always @(negedge clk) begin
        ev_t e;
        if (out_valid === 1'b1) begin
            e.cyc = cyc;
            e.acc = $signed(acc_out);
            e.dt  = dt;
            evq.push_back(e);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, output int acc_cyc);
        sample_in    = 16'(v);
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        acc_cyc      = cyc;
    endtask

    task automatic send_n(input int v, input int n);
        int c;
        for (int i = 0; i < n; i++) send(v, c);
    endtask

    task automatic calibrate(input int v, input int last);
        int c;
        calib_start = 1'b1;
        tick(1);
        calib_start = 1'b0;
        send_n(v, 15);
        send(last, c);
    endtask

    initial begin
        int c;
        int c4;
        int cb[8];
        int burst2[5];
        int exp2[5];

        vecs[0] = '{-31768, -31768,  32767, -32768,  32767};
        vecs[1] = '{ 32767,  32767, -32768,  31767, -32768};
        vecs[2] = '{  1000,   1000,   1006,      0, DB ? 1000 : 1006};
        vecs[3] = '{  1000,   1000,   1009,      0,   1009};
        vecs[4] = '{  1000,   1000,    992,      0, DB ? 1000 : 992};
        vecs[5] = '{-32768, -32768,      0, -32768,  32767};
        vecs[6] = '{ -1000,  -1001,  -3000,  -2001,   -999};
        vecs[7] = '{  1000,    985,   1000,     -1, DB ? 1000 : 1001};
        vecs[8] = '{  1000,   1015,    500,      0,    500};
        burst2  = '{1100, 1000, 1000, 1000, 1000};
        exp2    = '{1025, 1025, 1025, 1025, 1000};

        // Reset values
        rst = 1'b1;
        tick(3);
        check("rst_acc_out", acc_out, 0);
        check("rst_dt", dt, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_offset", offset, 0);
        check("rst_calib_done", calib_done, 0);
        rst = 1'b0;

        // Power-up calibration on 1040
        send_n(1040, 15);
        check("cal1_done_early", calib_done, 0);
        send(1040, c);
        check("cal1_done", calib_done, 1);
        check("cal1_offset", $signed(offset), 40);
        check("cal1_no_strobe", evq.size(), 0);

        // Spaced samples: dt counts ticks from calibration end
        send(1040, c);
        for (int i = 0; i < 3; i++) begin
            tick(29);
            send(1040, c);
        end
        c4 = c;
        tick(3);
        check("sp_count", evq.size(), 1);
        if (evq.size() >= 1) begin
            check("sp_latency", evq[0].cyc - c4, 1);
            check("sp_acc", evq[0].acc, 1000);
            check("sp_dt", evq[0].dt, 9);
        end
        evq.delete();
        tick(26);
        send(1140, c);
        tick(3);
        check("sp5_count", evq.size(), 1);
        if (evq.size() >= 1) begin
            check("sp5_acc", evq[0].acc, 1025);
            check("sp5_dt", evq[0].dt, 3);
        end

        // Table: calibration value/floor, saturation and dead-band cases
        for (int v = 0; v < 9; v++) begin
            calibrate(vecs[v].cal_val, vecs[v].cal_last);
            check($sformatf("vec%0d_offset", v), $signed(offset), vecs[v].exp_off);
            evq.delete();
            send_n(vecs[v].samp, 3);
            tick(2);
            check($sformatf("vec%0d_nofill", v), evq.size(), 0);
            send(vecs[v].samp, c);
            tick(3);
            check($sformatf("vec%0d_count", v), evq.size(), 1);
            if (evq.size() >= 1) check($sformatf("vec%0d_acc", v), evq[0].acc, vecs[v].exp_acc);
        end

        // Back-to-back samples with offset 0, then window eviction
        calibrate(1000, 1000);
        evq.delete();
        for (int i = 0; i < 8; i++) send(1000, cb[i]);
        tick(3);
        check("b2b_count", evq.size(), 5);
        for (int k = 0; k < 5 && k < evq.size(); k++) begin
            check($sformatf("b2b_acc%0d", k), evq[k].acc, 1000);
            check($sformatf("b2b_cyc%0d", k), evq[k].cyc, cb[k+3] + 1);
        end
        for (int i = 0; i < 5; i++) send(burst2[i], c);
        tick(3);
        check("wrap_count", evq.size(), 10);
        for (int k = 0; k < 5 && (k + 5) < evq.size(); k++)
            check($sformatf("wrap_acc%0d", k), evq[k+5].acc, exp2[k]);

        // calib_start with a result in flight and a coincident sample
        calibrate(1040, 1040);
        send_n(1040, 3);
        tick(2);
        evq.delete();
        send(1040, c);
        calib_start  = 1'b1;
        sample_in    = 16'(2000);
        sample_valid = 1'b1;
        tick(1);
        calib_start  = 1'b0;
        sample_valid = 1'b0;
        tick(3);
        check("abort_no_strobe", evq.size(), 0);
        check("abort_calib_done", calib_done, 0);
        send_n(1100, 15);
        check("abort_done_early", calib_done, 0);
        check("abort_offset_held", $signed(offset), 40);
        send(1100, c);
        check("abort_done", calib_done, 1);
        check("abort_offset", $signed(offset), 100);

        // Reset in the middle of a calibration, sample ignored during reset
        calib_start = 1'b1;
        tick(1);
        calib_start = 1'b0;
        send_n(1200, 5);
        rst          = 1'b1;
        sample_in    = 16'(1200);
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        check("mrst_acc_out", acc_out, 0);
        check("mrst_dt", dt, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_offset", offset, 0);
        check("mrst_calib_done", calib_done, 0);
        rst = 1'b0;
        evq.delete();
        send_n(1000, 15);
        check("mrst_done_early", calib_done, 0);
        send(1000, c);
        check("mrst_done", calib_done, 1);
        check("mrst_offset_new", $signed(offset), 0);
        check("mrst_no_strobe", evq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
